// File: rtl/disp_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl_pkg
// Purpose  : Shared definitions for the display scan controller: the FSM
//            state encoding, the blank-digit pattern and the hex-to-7-segment
//            lookup table (active-low, bit order gfedcba).
// Revision : 1.0 - initial release
// ============================================================================
package disp_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2
    } scan_state_t;

    // All segments off (active-low).
    localparam logic [6:0] c_blank = 7'b1111111;

    // Segment patterns for nibble values 0..F, gfedcba, active-low.
    localparam logic [6:0] c_seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return c_seg_table[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl_if
// Purpose  : Bundles the request inputs, register values and display outputs
//            of the display scan controller.
//   master : drives en, snap, MAR, R, AC, Z; observes HEX0..HEX6, busy,
//            frame_done
//   slave  : the controller side (inverse directions)
// Revision : 1.0 - initial release
// ============================================================================
interface disp_scan_ctrl_if;
    logic       en;
    logic       snap;
    logic [7:0] MAR;
    logic [7:0] R;
    logic [7:0] AC;
    logic       Z;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic [6:0] HEX6;
    logic       busy;
    logic       frame_done;

    modport master (
        output en, snap, MAR, R, AC, Z,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, busy, frame_done
    );

    modport slave (
        input  en, snap, MAR, R, AC, Z,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational hex nibble to 7-segment decoder (active-low,
//            gfedcba).
//   i_nibble : 4-bit value to display
//   o_seg    : segment pattern
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
    import disp_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg_lookup(i_nibble);

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Time-multiplexed refresh of seven hex digits from a snapshot of
//            MAR, R, AC and Z through one shared decoder. A frame is one LOAD
//            cycle (snapshot capture) followed by seven digit slots of
//            SCAN_DIV cycles each. Frames are requested continuously by en or
//            once by a snap pulse; snaps arriving mid-frame are remembered.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : disp_scan_ctrl_if.slave (requests, register values, HEX0..6,
//              busy, frame_done)
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4   // cycles per digit slot, 1..255
) (
    input  logic              clk,
    input  logic              rst,
    disp_scan_ctrl_if.slave   bus
);

    localparam logic [7:0] c_slot_last  = 8'(SCAN_DIV - 1);
    localparam logic [2:0] c_last_digit = 3'd6;
    localparam int         c_num_digits = 7;

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic [7:0] r_slot_cnt;
    logic [2:0] r_digit;
    logic [7:0] r_mar;
    logic [7:0] r_r;
    logic [7:0] r_ac;
    logic       r_z;
    logic       r_pending;
    logic       r_frame_done;
    logic [6:0] r_hex [c_num_digits];

    logic       w_slot_end;
    logic       w_capture;
    logic       w_commit;
    logic       w_frame_end;
    logic [3:0] w_nibble;
    logic [6:0] w_seg;

    assign w_slot_end = (r_slot_cnt == c_slot_last);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en || bus.snap) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_slot_end) begin
                    w_commit = 1'b1;
                    if (r_digit == c_last_digit) begin
                        w_frame_end = 1'b1;
                        // A snap arriving right now counts as pending too.
                        if (bus.en || bus.snap || r_pending) begin
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot / digit counters: both restart outside SCAN so every frame
    // begins at digit 0, slot cycle 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_digit    <= '0;
        end else if (r_state == ST_SCAN) begin
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_digit    <= (r_digit == c_last_digit) ? 3'd0 : r_digit + 3'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 8'd1;
            end
        end else begin
            r_slot_cnt <= '0;
            r_digit    <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot and pending snap request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mar <= '0;
            r_r   <= '0;
            r_ac  <= '0;
            r_z   <= 1'b0;
        end else if (w_capture) begin
            r_mar <= bus.MAR;
            r_r   <= bus.R;
            r_ac  <= bus.AC;
            r_z   <= bus.Z;
        end
    end

    // The frame-end transition consumes the pending request, so clear it
    // there; otherwise any snap during a frame (LOAD or SCAN) sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_frame_end) begin
            r_pending <= 1'b0;
        end else if ((r_state != ST_IDLE) && bus.snap) begin
            r_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shared decode path and digit registers
    // ------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        case (r_digit)
            3'd0:    w_nibble = r_mar[3:0];
            3'd1:    w_nibble = r_mar[7:4];
            3'd2:    w_nibble = r_r[3:0];
            3'd3:    w_nibble = r_r[7:4];
            3'd4:    w_nibble = r_ac[3:0];
            3'd5:    w_nibble = r_ac[7:4];
            3'd6:    w_nibble = {3'b000, r_z};
            default: w_nibble = 4'h0;
        endcase
    end

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_num_digits; k++) begin
                r_hex[k] <= c_blank;
            end
        end else begin
            for (int k = 0; k < c_num_digits; k++) begin
                if (w_commit && (r_digit == 3'(k))) begin
                    r_hex[k] <= w_seg;
                end
            end
        end
    end

    // frame_done coincides with HEX6 taking its new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
        end
    end

    assign bus.HEX0       = r_hex[0];
    assign bus.HEX1       = r_hex[1];
    assign bus.HEX2       = r_hex[2];
    assign bus.HEX3       = r_hex[3];
    assign bus.HEX4       = r_hex[4];
    assign bus.HEX5       = r_hex[5];
    assign bus.HEX6       = r_hex[6];
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
